// File: rtl/cs_rst_pkg.sv
// Shared types and constants for the cs subsystem reset sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cs_rst_pkg;

    // Sequencer phases: idle, assert/hold, staggered release
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        REL  = 2'd2
    } state_t;

    // Reset scope: whole subsystem (link/global) or acquisition restart only
    typedef enum logic {
        SC_ALL = 1'b0,
        SC_RUN = 1'b1
    } scope_t;

    // Default channel map; the index is also the release order
    localparam int CH_CS_COM    = 0;
    localparam int CH_MAC       = 1;
    localparam int CH_ADC       = 2;
    localparam int CH_FIFOC     = 3;
    localparam int CH_FIFOD     = 4;
    localparam int CH_MAC2FIFOC = 5;
    localparam int CH_FIFOC2CS  = 6;
    localparam int CH_ADC2FIFOD = 7;
    localparam int CH_FIFOD2MAC = 8;

    localparam int             CS_NUM_CH   = 9;
    // mac and fifoc belong to the link and survive an acquisition restart
    localparam logic [8:0]     CS_RUN_MASK = 9'b111110101;

endpackage

// File: rtl/cs_rst_timer.sv
// Cycle timer for the reset sequencer: up-counter with clear, hold and terminal flag.
// Latency: tc is combinational from the count register; count updates on the next edge.
// Backpressure: none; the counter holds its value whenever inc is low.
//
// Ports: clk, rst (sync, active-high), clr (zero the count), inc (advance by one),
//        term (terminal value to compare against), tc (count == term).
module cs_rst_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/cs_rst_seq.sv
// Reset sequencer: asserts per-domain resets by scope, holds them, then releases in index order.
// Latency: rst_ch updates on the edge a request is sampled; status follows rst_ch with no extra delay.
// Backpressure: none; a new request at any time restarts the sequence, nothing is ever stalled.
//
// Ports: clk, rst (sync, active-high, acts as a held rst_all_req), rst_all_req, rst_run_req,
//        rst_ch[NUM_CH] (registered per-channel resets), busy, run_ready, all_ready.
module cs_rst_seq
    import cs_rst_pkg::*;
#(
    parameter int NUM_CH   = CS_NUM_CH,
    parameter     RUN_MASK = CS_RUN_MASK,
    parameter int HOLD_CYC = 16,
    parameter int STAGGER  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_all_req,
    input  logic              rst_run_req,
    output logic [NUM_CH-1:0] rst_ch,
    output logic              busy,
    output logic              run_ready,
    output logic              all_ready
);

    localparam int MAX_CYC = (HOLD_CYC > STAGGER) ? HOLD_CYC : STAGGER;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [NUM_CH-1:0] RUN_M     = NUM_CH'(RUN_MASK);
    localparam logic [CNT_W-1:0]  HOLD_TERM = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]  STAG_TERM = CNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CH - 1);

    if (NUM_CH < 1 || HOLD_CYC < 1 || STAGGER < 1 || $bits(RUN_MASK) != NUM_CH) begin : g_param_err
        $error("cs_rst_seq: illegal parameter set");
    end

    state_t           state;
    scope_t           scope;
    logic [IDX_W-1:0] idx;

    logic             any_req;
    logic             idx_in_scope;
    logic             idx_last;
    logic             tmr_clr;
    logic             tmr_inc;
    logic             tmr_tc;
    logic [CNT_W-1:0] tmr_term;

    assign any_req      = rst_all_req | rst_run_req;
    assign idx_in_scope = (scope == SC_ALL) || RUN_M[idx];
    assign idx_last     = (idx == LAST_IDX);

    // One timer serves both phases; only the terminal value changes
    assign tmr_term = (state == HOLD) ? HOLD_TERM : STAG_TERM;

    always_comb begin
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        if (rst || any_req) begin
            // A request pins the hold count at zero for as long as it is high
            tmr_clr = 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    if (tmr_tc) tmr_clr = 1'b1;
                    else        tmr_inc = 1'b1;
                end
                REL: begin
                    // Out-of-scope channels are skipped in one cycle with the timer parked
                    if (idx_in_scope) begin
                        if (tmr_tc) tmr_clr = 1'b1;
                        else        tmr_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    cs_rst_timer #(
        .W    (CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .inc  (tmr_inc),
        .term (tmr_term),
        .tc   (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_ch <= '1;
            state  <= HOLD;
            scope  <= SC_ALL;
            idx    <= '0;
        end else if (any_req) begin
            // OR in the new set: channels already held stay held, released ones re-assert
            rst_ch <= rst_ch | (rst_all_req ? {NUM_CH{1'b1}} : RUN_M);
            state  <= HOLD;
            idx    <= '0;
            // An ALL sequence in flight is never narrowed by a later RUN request
            if (rst_all_req || (state != IDLE && scope == SC_ALL)) scope <= SC_ALL;
            else                                                 scope <= SC_RUN;
        end else begin
            case (state)
                HOLD: begin
                    if (tmr_tc) begin
                        state <= REL;
                        idx   <= '0;
                    end
                end
                REL: begin
                    if (!idx_in_scope || tmr_tc) begin
                        if (idx_in_scope) rst_ch[idx] <= 1'b0;
                        if (idx_last) state <= IDLE;
                        else          idx   <= idx + IDX_W'(1);
                    end
                end
                IDLE: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign run_ready = ~|(rst_ch & RUN_M);
    assign all_ready = ~|rst_ch;

endmodule

// File: tb/tb_cs_rst_seq.sv
module tb_cs_rst_seq;
    import cs_rst_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_all_req, rst_run_req;
    logic [8:0] d0_rst_ch;
    logic       d0_busy, d0_run_ready, d0_all_ready;
    logic [2:0] d1_rst_ch;
    logic       d1_busy, d1_run_ready, d1_all_ready;

    cs_rst_seq u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .rst_all_req (rst_all_req),
        .rst_run_req (rst_run_req),
        .rst_ch      (d0_rst_ch),
        .busy        (d0_busy),
        .run_ready   (d0_run_ready),
        .all_ready   (d0_all_ready)
    );

    cs_rst_seq #(
        .NUM_CH   (3),
        .RUN_MASK (3'b101),
        .HOLD_CYC (1),
        .STAGGER  (1)
    ) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .rst_all_req (rst_all_req),
        .rst_run_req (rst_run_req),
        .rst_ch      (d1_rst_ch),
        .busy        (d1_busy),
        .run_ready   (d1_run_ready),
        .all_ready   (d1_all_ready)
    );

    // Reference model: each request computes an absolute release schedule
    int         P_N[2]    = '{9, 3};
    int         P_HOLD[2] = '{16, 1};
    int         P_STG[2]  = '{4, 1};
    logic [8:0] P_MASK[2] = '{9'b111110101, 9'b000000101};

    logic [8:0] m_rst[2];
    bit         m_all[2];
    int         m_end[2];
    int         m_rel[2][9];
    int         fall[2][9];
    logic [8:0] prev_rst[2];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h at edge %0d", tag, obs, exp, cyc);
    endtask

    task automatic model_edge(input int d, input bit r, input bit a, input bit u);
        bit         busy_prev;
        logic [8:0] ones;
        int         t;
        busy_prev = (cyc - 1) < m_end[d];
        ones      = 9'((1 << P_N[d]) - 1);
        if (r || a || u) begin
            m_all[d] = r || a || (busy_prev && m_all[d]);
            m_rst[d] = m_rst[d] | ((r || a) ? ones : P_MASK[d]);
            t = cyc + P_HOLD[d];
            for (int k = 0; k < 9; k++) begin
                m_rel[d][k] = -1;
                if (k < P_N[d]) begin
                    if (m_all[d] || P_MASK[d][k]) begin
                        t = t + P_STG[d];
                        m_rel[d][k] = t;
                    end else begin
                        t = t + 1;
                    end
                end
            end
            m_end[d] = t;
        end else begin
            for (int k = 0; k < 9; k++)
                if (m_rel[d][k] == cyc) m_rst[d][k] = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit a, input bit u);
        logic [8:0] o_rst;
        logic       o_busy, o_rr, o_ar;
        rst = r; rst_all_req = a; rst_run_req = u;
        @(posedge clk);
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            model_edge(d, r, a, u);
            o_rst  = (d == 0) ? d0_rst_ch    : {6'b0, d1_rst_ch};
            o_busy = (d == 0) ? d0_busy      : d1_busy;
            o_rr   = (d == 0) ? d0_run_ready : d1_run_ready;
            o_ar   = (d == 0) ? d0_all_ready : d1_all_ready;
            check($sformatf("d%0d rst_ch", d), 32'(o_rst), 32'(m_rst[d]));
            check($sformatf("d%0d busy", d), 32'(o_busy), 32'(cyc < m_end[d]));
            check($sformatf("d%0d run_ready", d), 32'(o_rr), 32'(~|(m_rst[d] & P_MASK[d])));
            check($sformatf("d%0d all_ready", d), 32'(o_ar), 32'(~|m_rst[d]));
            for (int k = 0; k < P_N[d]; k++)
                if (prev_rst[d][k] === 1'b1 && o_rst[k] === 1'b0) fall[d][k] = cyc;
            prev_rst[d] = o_rst;
        end
    endtask

    task automatic wait_release(input int k);
        int w = 0;
        while (d0_rst_ch[k] !== 1'b0 && w < 100) begin
            step(1'b0, 1'b0, 1'b0);
            w++;
        end
        check($sformatf("wait ch%0d release", k), 32'(d0_rst_ch[k]), 32'd0);
    endtask

    initial begin
        int t0, te, tf, ta, tr, rr, span;
        for (int d = 0; d < 2; d++) begin
            m_rst[d] = '0; m_all[d] = 1'b1; m_end[d] = 0; prev_rst[d] = '0;
            for (int k = 0; k < 9; k++) begin
                m_rel[d][k] = -1;
                fall[d][k]  = -1;
            end
        end
        rst = 1'b1; rst_all_req = 1'b0; rst_run_req = 1'b0;

        // Reset state and the power-on ALL release
        repeat (3) step(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        check("reset rst_ch", 32'(d0_rst_ch), 32'h1ff);
        check("reset busy", 32'(d0_busy), 32'd1);
        check("reset run_ready", 32'(d0_run_ready), 32'd0);
        check("reset all_ready", 32'(d0_all_ready), 32'd0);
        repeat (60) step(1'b0, 1'b0, 1'b0);
        check("por ch0 fall", 32'(fall[0][CH_CS_COM] - t0), 32'd20);
        check("por ch8 fall", 32'(fall[0][CH_FIFOD2MAC] - t0), 32'd52);
        check("por idle", 32'(d0_busy), 32'd0);
        check("small por ch0", 32'(fall[1][0] - t0), 32'd2);
        check("small por ch1", 32'(fall[1][1] - t0), 32'd3);
        check("small por ch2", 32'(fall[1][2] - t0), 32'd4);

        // Single-cycle RUN request from IDLE
        step(1'b0, 1'b0, 1'b1);
        te = cyc;
        check("run set", 32'(d0_rst_ch), 32'h1f5);
        check("small run set", 32'(d1_rst_ch), 32'h5);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        check("run ch0 fall", 32'(fall[0][CH_CS_COM] - te), 32'd20);
        check("run ch2-ch0", 32'(fall[0][CH_ADC] - fall[0][CH_CS_COM]), 32'd5);
        check("run ch8-ch0", 32'(fall[0][CH_FIFOD2MAC] - fall[0][CH_CS_COM]), 32'd26);
        check("small run ch2", 32'(fall[1][2] - te), 32'd4);

        // RUN request held for 10 cycles
        step(1'b0, 1'b0, 1'b1);
        tf = cyc;
        repeat (9) step(1'b0, 1'b0, 1'b1);
        repeat (50) step(1'b0, 1'b0, 1'b0);
        check("held ch0 fall", 32'(fall[0][CH_CS_COM] - tf), 32'd29);

        // ALL request during RUN release, after ch4 is out
        step(1'b0, 1'b0, 1'b1);
        wait_release(CH_FIFOD);
        step(1'b0, 1'b1, 1'b0);
        ta = cyc;
        check("all over run set", 32'(d0_rst_ch), 32'h1ff);
        repeat (60) step(1'b0, 1'b0, 1'b0);
        check("all over run ch0", 32'(fall[0][CH_CS_COM] - ta), 32'd20);
        check("all over run ch8", 32'(fall[0][CH_FIFOD2MAC] - ta), 32'd52);
        check("all over run span", 32'(fall[0][CH_FIFOD2MAC] - fall[0][CH_CS_COM]), 32'd32);

        // RUN request during ALL release, after ch5 is out: scope stays ALL
        step(1'b0, 1'b1, 1'b0);
        wait_release(CH_MAC2FIFOC);
        step(1'b0, 1'b0, 1'b1);
        tr = cyc;
        check("run over all set", 32'(d0_rst_ch), 32'h1f5);
        repeat (60) step(1'b0, 1'b0, 1'b0);
        check("run over all ch2", 32'(fall[0][CH_ADC] - tr), 32'd28);
        check("run over all ch8", 32'(fall[0][CH_FIFOD2MAC] - tr), 32'd52);

        // Randomized requests, dense then sparse
        for (int i = 0; i < 3000; i++) begin
            span = (i < 1500) ? 30 : 120;
            rr = int'($urandom_range(0, span - 1));
            step(rr == 0, rr == 1 || rr == 3, rr == 2 || rr == 3 || rr == 4);
        end
        repeat (60) step(1'b0, 1'b0, 1'b0);
        check("final all_ready", 32'(d0_all_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
